ssd_frame_monitor: RTL
======================

# ssd_frame_monitor

Board-level self-check block that reads back the six active-low seven-segment buses driven by the scrolling-message display logic, decodes each glyph into a 3-bit symbol code, and tracks whether successive frames are one-position rotations of each other. It sits beside the display driver on the HEX5..HEX0 nets and reports frame contents, rotation steps, resynchronisations and illegal glyphs. The display logic is unaffected.

## Interface
- Parameters: none. Glyph patterns, symbol codes and digit count are fixed in the shared package.
- CLOCK_50  in  1  system clock; all logic on rising edge
- Reset  in  1  one clock; reset is synchronous and active-high
- sample_en  in  1  single-cycle request to capture and evaluate the current HEX buses
- HEX5..HEX0  in  7 each  active-low segment buses; bit i = segment i (a=0 … g=6)
- frame  out  18  last valid decoded frame; digit i at bits [3i+2:3i]
- frame_valid  out  1  one-cycle pulse: frame updated
- rot_step  out  1  one-cycle pulse: new frame is previous frame rotated by one
- resync  out  1  one-cycle pulse: new frame is neither equal to nor a rotation of previous
- bad_glyph  out  1  one-cycle pulse: at least one digit matched no glyph
- rot_count  out  3  rotation counter, 0..5
- busy  out  1  high while a capture is being evaluated

## Operation
- Glyph alphabet, code : pattern: 0 d 7'b0100001, 1 E 7'b0000110, 2 "1" 7'b1111001, 3 "0" 7'b1000000, 4 blank 7'b1111111, 5 H 7'b0001001, 6 L 7'b1000111, 7 P 7'b0001100. Any other pattern is illegal.
- FSM states:
  - IDLE: sample_en=1 latches all six buses; go to DECODE with idx=0.
  - DECODE: six cycles, one digit per cycle, idx 0..5, through a single glyph decoder. Writes the code into a working frame and ORs an illegal flag. After idx=5, go to CMP.
  - CMP: one cycle to evaluate; go to IDLE.
- CMP rules, in priority order:
  - Illegal flag set: bad_glyph pulse only. frame, previous frame, prev_valid and rot_count are unchanged.
  - prev_valid=0 (first frame after reset): store the frame, set prev_valid, frame_valid pulse. rot_step=0, rot_count=0.
  - new == prev: frame_valid pulse; count held.
  - new[i] == prev[(i+5) mod 6] for all i (each symbol moves one display left; HEX5 wraps to HEX0): frame_valid and rot_step pulse. rot_count increments and wraps 5→0.
  - Otherwise: frame_valid and resync pulse; rot_count ← 0.
- In every legal case, frame and the previous-frame register take the new frame.
- sample_en while busy=1 is ignored, not queued.
- Reset mid-operation: abort the evaluation, return to IDLE, and clear prev_valid and all state. No pulses are emitted for the aborted frame.
- Reset values: frame=0, rot_count=0, all pulses=0, busy=0, prev_valid=0.

## Timing
- sample_en is sampled high at edge E0; buses are latched at E0.
- busy is high from E0 to E0+7 (7 cycles) and low after E0+7.
- DECODE runs on edges E0+1..E0+6; CMP registers its results at E0+7.
- Pulses are high for exactly the cycle between E0+7 and E0+8. frame and rot_count change at E0+7.
- Earliest next accepted sample_en is the cycle after E0+7, so the back-to-back period is 8 cycles.
- Bus changes after E0 do not affect the evaluation in progress.

## Structure
- Package ssd_glyph_pkg holds:
  - the 7-bit glyph constants and 3-bit symbol code constants
  - NUM_DIGITS=6 and the state enum {IDLE, DECODE, CMP}
- Sub-module ssd_glyph_decode is combinational: 7-bit pattern in, 3-bit code and legal flag out. It is instantiated once and muxed by idx.
- Top level contains the FSM, the capture registers, working/previous frame registers, comparators and rot_count.

## Test plan
- Reset, then sample HEX5..0 = H,E,L,L,0,blank. Required at E0+7: frame_valid=1, frame=18'b101_001_110_110_011_100, rot_step=0, rot_count=0.
- Follow with HEX5..0 = E,L,L,0,blank,H. Required: frame_valid=1, rot_step=1, rot_count=1.
- Six successive one-step rotations. Required: rot_count 1,2,3,4,5,0 (wraps); rot_step pulses each time.
- Identical frame sampled twice. Required: second evaluation gives frame_valid=1, rot_step=0, resync=0, rot_count held. Separately, an unrelated legal frame gives resync=1 and rot_count=0.
- HEX2=7'b0110110 in an otherwise legal frame. Required: bad_glyph=1, frame_valid=0, frame and rot_count unchanged. A sample_en pulsed at E0+3 is ignored: no second evaluation occurs.
- Reset asserted during DECODE idx=3. Required: busy=0 after that edge and no pulses. The next legal sample behaves as a first frame: rot_step=0, rot_count=0.

Source files
------------

// File: rtl/ssd_frame_monitor_pkg.sv
// Shared glyph table, symbol codes and FSM state type for the seven-segment frame monitor.
// Patterns are active-low, bit i = segment i (a=0 .. g=6).
package ssd_glyph_pkg;
    localparam int NUM_DIGITS = 6;
    localparam int FRAME_W    = 3 * NUM_DIGITS;

    localparam logic [6:0] GLYPH_D     = 7'b0100001;
    localparam logic [6:0] GLYPH_E     = 7'b0000110;
    localparam logic [6:0] GLYPH_ONE   = 7'b1111001;
    localparam logic [6:0] GLYPH_ZERO  = 7'b1000000;
    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;
    localparam logic [6:0] GLYPH_H     = 7'b0001001;
    localparam logic [6:0] GLYPH_L     = 7'b1000111;
    localparam logic [6:0] GLYPH_P     = 7'b0001100;

    localparam logic [2:0] SYM_D     = 3'd0;
    localparam logic [2:0] SYM_E     = 3'd1;
    localparam logic [2:0] SYM_ONE   = 3'd2;
    localparam logic [2:0] SYM_ZERO  = 3'd3;
    localparam logic [2:0] SYM_BLANK = 3'd4;
    localparam logic [2:0] SYM_H     = 3'd5;
    localparam logic [2:0] SYM_L     = 3'd6;
    localparam logic [2:0] SYM_P     = 3'd7;

    typedef enum logic [1:0] {IDLE, DECODE, CMP} state_t;
endpackage

// File: rtl/ssd_frame_monitor_if.sv
// Display-side bundle: HEX buses and capture request in, decoded frame and status pulses out.
interface ssd_frame_monitor_if;
    import ssd_glyph_pkg::*;

    logic                 sample_en;
    logic [6:0]           HEX5, HEX4, HEX3, HEX2, HEX1, HEX0;
    logic [FRAME_W-1:0]   frame;
    logic                 frame_valid;
    logic                 rot_step;
    logic                 resync;
    logic                 bad_glyph;
    logic [2:0]           rot_count;
    logic                 busy;

    modport master (
        output sample_en, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0,
        input  frame, frame_valid, rot_step, resync, bad_glyph, rot_count, busy
    );

    modport slave (
        input  sample_en, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0,
        output frame, frame_valid, rot_step, resync, bad_glyph, rot_count, busy
    );
endinterface

// File: rtl/ssd_frame_monitor_glyph_decode.sv
// Combinational glyph decoder: 7-bit active-low pattern to 3-bit symbol code plus legal flag.
module ssd_glyph_decode
    import ssd_glyph_pkg::*;
(
    input  logic [6:0] i_pat,
    output logic [2:0] o_code,
    output logic       o_legal
);
    always_comb begin
        o_code  = SYM_BLANK;
        o_legal = 1'b1;
        case (i_pat)
            GLYPH_D:     o_code = SYM_D;
            GLYPH_E:     o_code = SYM_E;
            GLYPH_ONE:   o_code = SYM_ONE;
            GLYPH_ZERO:  o_code = SYM_ZERO;
            GLYPH_BLANK: o_code = SYM_BLANK;
            GLYPH_H:     o_code = SYM_H;
            GLYPH_L:     o_code = SYM_L;
            GLYPH_P:     o_code = SYM_P;
            default:     o_legal = 1'b0;
        endcase
    end
endmodule

// File: rtl/ssd_frame_monitor.sv
// Captures the six HEX buses, decodes one digit per cycle, then classifies the frame against the previous one.
// Capture-to-result latency is 7 cycles; sample_en while busy is dropped, not queued.
module ssd_frame_monitor
    import ssd_glyph_pkg::*;
(
    input  logic                CLOCK_50,
    input  logic                Reset,
    ssd_frame_monitor_if.slave  mon
);
    state_t               r_state;
    logic [6:0]           r_cap [NUM_DIGITS];
    logic [2:0]           r_idx;
    logic [FRAME_W-1:0]   r_work;
    logic [FRAME_W-1:0]   r_prev;
    logic [FRAME_W-1:0]   r_frame;
    logic                 r_illegal;
    logic                 r_prev_valid;
    logic [2:0]           r_rot_count;
    logic                 r_busy;
    logic                 r_frame_valid;
    logic                 r_rot_step;
    logic                 r_resync;
    logic                 r_bad_glyph;

    logic [6:0]           w_pat;
    logic [2:0]           w_code;
    logic                 w_legal;
    logic [FRAME_W-1:0]   w_rot;
    logic                 w_equal;
    logic                 w_is_rot;

    always_comb begin
        case (r_idx)
            3'd0:    w_pat = r_cap[0];
            3'd1:    w_pat = r_cap[1];
            3'd2:    w_pat = r_cap[2];
            3'd3:    w_pat = r_cap[3];
            3'd4:    w_pat = r_cap[4];
            default: w_pat = r_cap[5];
        endcase
    end

    ssd_glyph_decode u_decode (
        .i_pat   (w_pat),
        .o_code  (w_code),
        .o_legal (w_legal)
    );

    // Expected frame if every symbol moved one display left, HEX5 wrapping into HEX0.
    always_comb begin
        w_rot = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_rot[3*i +: 3] = r_prev[3*((i + NUM_DIGITS - 1) % NUM_DIGITS) +: 3];
        end
    end

    assign w_equal  = (r_work == r_prev);
    assign w_is_rot = (r_work == w_rot);

    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            r_state       <= IDLE;
            r_idx         <= '0;
            r_work        <= '0;
            r_prev        <= '0;
            r_frame       <= '0;
            r_illegal     <= 1'b0;
            r_prev_valid  <= 1'b0;
            r_rot_count   <= '0;
            r_busy        <= 1'b0;
            r_frame_valid <= 1'b0;
            r_rot_step    <= 1'b0;
            r_resync      <= 1'b0;
            r_bad_glyph   <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) r_cap[i] <= '0;
        end else begin
            r_frame_valid <= 1'b0;
            r_rot_step    <= 1'b0;
            r_resync      <= 1'b0;
            r_bad_glyph   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (mon.sample_en) begin
                        r_cap[0]  <= mon.HEX0;
                        r_cap[1]  <= mon.HEX1;
                        r_cap[2]  <= mon.HEX2;
                        r_cap[3]  <= mon.HEX3;
                        r_cap[4]  <= mon.HEX4;
                        r_cap[5]  <= mon.HEX5;
                        r_idx     <= '0;
                        r_illegal <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= DECODE;
                    end
                end
                DECODE: begin
                    r_work[3*r_idx +: 3] <= w_code;
                    if (!w_legal) r_illegal <= 1'b1;
                    if (r_idx == 3'(NUM_DIGITS - 1)) r_state <= CMP;
                    else                             r_idx   <= r_idx + 3'd1;
                end
                CMP: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                    if (r_illegal) begin
                        r_bad_glyph <= 1'b1;
                    end else begin
                        r_frame_valid <= 1'b1;
                        r_frame       <= r_work;
                        r_prev        <= r_work;
                        r_prev_valid  <= 1'b1;
                        // Equality outranks rotation so a uniform frame holds the count.
                        if (!r_prev_valid) begin
                            r_rot_count <= '0;
                        end else if (!w_equal) begin
                            if (w_is_rot) begin
                                r_rot_step  <= 1'b1;
                                r_rot_count <= (r_rot_count == 3'd5) ? 3'd0 : r_rot_count + 3'd1;
                            end else begin
                                r_resync    <= 1'b1;
                                r_rot_count <= '0;
                            end
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign mon.frame       = r_frame;
    assign mon.frame_valid = r_frame_valid;
    assign mon.rot_step    = r_rot_step;
    assign mon.resync      = r_resync;
    assign mon.bad_glyph   = r_bad_glyph;
    assign mon.rot_count   = r_rot_count;
    assign mon.busy        = r_busy;
endmodule
